oc8051_tc_seq: RTL and testbench
================================

# oc8051_tc_seq

Timer/counter configuration sequencer sitting between the CPU SFR write path and the timer/counter block's SFR write port. On a single start command it loads a snapshot of TMOD, TH0, TL0, TH1 and TL1 through the shared write port in a fixed order, yielding every cycle to CPU SFR writes, then signals completion and optionally requests the timer run bits. It lets boot/debug logic bring both timers to a known configuration without CPU instructions.

## Interface

- AUTO_RUN, 1: when 1, `tr0_set`/`tr1_set` pulse on completion per `cfg_run`; when 0 they stay low.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_wr  in  1  CPU SFR write strobe
- cpu_wr_bit  in  1  CPU bit-write qualifier
- cpu_wr_addr  in  8  CPU SFR write address
- cpu_data_in  in  8  CPU SFR write data
- cfg_start  in  1  start request, sampled only in IDLE
- cfg_mask  in  5  per-register enable: [0]TMOD [1]TH0 [2]TL0 [3]TH1 [4]TL1
- cfg_tmod, cfg_th0, cfg_tl0, cfg_th1, cfg_tl1  in  8 each  values to load
- cfg_run  in  2  [0]/[1]: request tr0/tr1 set on completion
- wr  out  1  write strobe to timer/counter port
- wr_bit  out  1  bit-write qualifier to timer/counter port
- wr_addr  out  8  write address to timer/counter port
- data_in  out  8  write data to timer/counter port
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- tr0_set, tr1_set  out  1 each  one-cycle run-bit set requests to TCON logic

## Operation

- States: IDLE, S_TMOD, S_TH0, S_TL0, S_TH1, S_TL1, DONE (one-hot or encoded, implementer's choice).
- IDLE: `cfg_start`=1 at a clock edge → snapshot `cfg_mask`, all five `cfg_*` values and `cfg_run` into internal registers; next state S_TMOD. Start in any other state ignored; cfg inputs outside the accepting edge have no effect.
- Step state Sx with mask bit set: sequencer issues write {addr Sx, snapshot value, wr_bit=0}. Addresses: TMOD 0x89, TL0 0x8A, TL1 0x8B, TH0 0x8C, TH1 0x8D.
- Step state with mask bit clear: no write issued, advance unconditionally after one cycle.
- Arbitration, CPU absolute priority: if `cpu_wr`=1 the output port carries the CPU request unchanged (`wr`,`wr_bit`,`wr_addr`,`data_in` = cpu_*), and the current enabled step holds (does not advance). Enabled step advances only on a cycle where `cpu_wr`=0.
- CPU write to a register not yet sequenced is overwritten later by the sequencer; no address comparison.
- Output mux is combinational from `cpu_*` and state; when neither source writes: `wr`=0, `wr_bit`=0, `wr_addr`=0x00, `data_in`=0x00.
- S_TL1 advance → DONE. DONE lasts exactly one cycle: `done`=1; `tr0_set`=AUTO_RUN&run[0], `tr1_set`=AUTO_RUN&run[1]; then IDLE.
- `busy`=1 in every state except IDLE (registered decode, not combinational from `cfg_start`).

## Timing

- Reset (rst=0, asynchronous): state IDLE, snapshots cleared to 0, `busy`=0, `done`=0, `tr0_set`=0, `tr1_set`=0; port outputs follow `cpu_*` (zero when CPU idle). Reset mid-sequence abandons remaining steps; writes already issued are not undone; no `done`.
- Start accepted at edge E0 → S_TMOD during cycle E0..E1; with no CPU contention the five steps occupy cycles 1–5, DONE cycle 6, IDLE cycle 7. Start-to-done latency 6 cycles regardless of mask.
- Each cycle of `cpu_wr`=1 during an enabled step adds exactly one cycle; during a disabled step adds zero.
- `cfg_start` held high through DONE does not restart until the cycle after DONE (IDLE); a start sampled in that IDLE cycle is accepted (back-to-back sequences, 7-cycle period).
- cfg_mask=0: no writes, `done` still at cycle 6.

## Test plan

- Reset then start, mask=5'h1F, tmod=0x21, th0=0xF0, tl0=0x10, th1=0xFD, tl1=0xFD, no CPU traffic → writes (0x89,0x21),(0x8C,0xF0),(0x8A,0x10),(0x8D,0xFD),(0x8B,0xFD) in cycles 1–5, `done` cycle 6, `busy` cycles 1–6.
- Same start, `cpu_wr`=1 addr 0xA8 data 0x82 in cycles 2 and 3 → port shows CPU write both cycles, TH0 write in cycle 4, `done` cycle 8.
- mask=5'b00101 → only TMOD (cycle 1) and TL0 (cycle 3) writes, `wr`=0 cycles 2,4,5, `done` cycle 6.
- AUTO_RUN=1, cfg_run=2'b10 → `tr1_set`=1, `tr0_set`=0 in cycle 6 only; AUTO_RUN=0 → both stay 0.
- Second `cfg_start` in cycle 3 with different cfg values → ignored, original values written; start held continuously → next sequence begins cycle 8.
- rst low asynchronously in cycle 3 → `busy` drops immediately, no further writes, no `done`; start after release runs a full 6-cycle sequence.

Source files
------------

// File: rtl/oc8051_tc_seq.sv
// ---------------------------------------------------------------------------
// oc8051_tc_seq
//
// Timer/counter configuration sequencer. A start command takes a snapshot of
// TMOD/TH0/TL0/TH1/TL1 and an enable mask. The sequencer then writes each
// enabled register through the timer/counter SFR write port in a fixed order:
// TMOD, TH0, TL0, TH1, TL1. CPU SFR writes always win the shared port and
// stall the sequencer. When the sequence finishes, the block pulses done for
// one cycle. It can also request the TR0/TR1 run bits.
//
// Parameters:
//   AUTO_RUN     1: tr0_set/tr1_set pulse on completion per cfg_run
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   cpu_wr       CPU SFR write strobe
//   cpu_wr_bit   CPU bit-write qualifier
//   cpu_wr_addr  CPU SFR write address
//   cpu_data_in  CPU SFR write data
//   cfg_start    start request (accepted only while idle)
//   cfg_mask     per-register enable [0]TMOD [1]TH0 [2]TL0 [3]TH1 [4]TL1
//   cfg_tmod..cfg_tl1  values to load
//   cfg_run      [0]/[1] request tr0/tr1 set on completion
//   wr, wr_bit, wr_addr, data_in  write port to the timer/counter block
//   busy         sequence in progress
//   done         one-cycle completion pulse
//   tr0_set, tr1_set  one-cycle run-bit set requests
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module oc8051_tc_seq #(
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic       cpu_wr_bit,
  input  logic [7:0] cpu_wr_addr,
  input  logic [7:0] cpu_data_in,
  input  logic       cfg_start,
  input  logic [4:0] cfg_mask,
  input  logic [7:0] cfg_tmod,
  input  logic [7:0] cfg_th0,
  input  logic [7:0] cfg_tl0,
  input  logic [7:0] cfg_th1,
  input  logic [7:0] cfg_tl1,
  input  logic [1:0] cfg_run,
  output logic       wr,
  output logic       wr_bit,
  output logic [7:0] wr_addr,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       tr0_set,
  output logic       tr1_set
);

  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_TL0  = 8'h8A;
  localparam logic [7:0] ADDR_TL1  = 8'h8B;
  localparam logic [7:0] ADDR_TH0  = 8'h8C;
  localparam logic [7:0] ADDR_TH1  = 8'h8D;

  typedef enum logic [2:0] {
    IDLE,
    S_TMOD,
    S_TH0,
    S_TL0,
    S_TH1,
    S_TL1,
    DONE
  } state_t;

  state_t     state;
  logic [4:0] mask_q;
  logic [7:0] tmod_q;
  logic [7:0] th0_q;
  logic [7:0] tl0_q;
  logic [7:0] th1_q;
  logic [7:0] tl1_q;
  logic [1:0] run_q;

  logic       step_en;
  logic [7:0] step_addr;
  logic [7:0] step_data;
  logic       advance;

  // Decode the register handled by the current step and whether it is enabled.
  always_comb begin
    step_en   = 1'b0;
    step_addr = 8'h00;
    step_data = 8'h00;
    case (state)
      S_TMOD: begin step_en = mask_q[0]; step_addr = ADDR_TMOD; step_data = tmod_q; end
      S_TH0:  begin step_en = mask_q[1]; step_addr = ADDR_TH0;  step_data = th0_q;  end
      S_TL0:  begin step_en = mask_q[2]; step_addr = ADDR_TL0;  step_data = tl0_q;  end
      S_TH1:  begin step_en = mask_q[3]; step_addr = ADDR_TH1;  step_data = th1_q;  end
      S_TL1:  begin step_en = mask_q[4]; step_addr = ADDR_TL1;  step_data = tl1_q;  end
      default: ;
    endcase
  end

  // A disabled step never waits. An enabled step waits only while the CPU owns the port.
  assign advance = !(step_en && cpu_wr);

  // Port mux: the CPU has absolute priority and passes through unchanged.
  always_comb begin
    wr      = 1'b0;
    wr_bit  = 1'b0;
    wr_addr = 8'h00;
    data_in = 8'h00;
    if (cpu_wr) begin
      wr      = 1'b1;
      wr_bit  = cpu_wr_bit;
      wr_addr = cpu_wr_addr;
      data_in = cpu_data_in;
    end else if (step_en) begin
      wr      = 1'b1;
      wr_addr = step_addr;
      data_in = step_data;
    end
  end

  // Sequencer FSM. busy/done/tr*_set are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mask_q  <= 5'h00;
      tmod_q  <= 8'h00;
      th0_q   <= 8'h00;
      tl0_q   <= 8'h00;
      th1_q   <= 8'h00;
      tl1_q   <= 8'h00;
      run_q   <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      tr0_set <= 1'b0;
      tr1_set <= 1'b0;
    end else begin
      done    <= 1'b0;
      tr0_set <= 1'b0;
      tr1_set <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            mask_q <= cfg_mask;
            tmod_q <= cfg_tmod;
            th0_q  <= cfg_th0;
            tl0_q  <= cfg_tl0;
            th1_q  <= cfg_th1;
            tl1_q  <= cfg_tl1;
            run_q  <= cfg_run;
            state  <= S_TMOD;
            busy   <= 1'b1;
          end
        end
        S_TMOD: if (advance) state <= S_TH0;
        S_TH0:  if (advance) state <= S_TL0;
        S_TL0:  if (advance) state <= S_TH1;
        S_TH1:  if (advance) state <= S_TL1;
        S_TL1: begin
          if (advance) begin
            state   <= DONE;
            done    <= 1'b1;
            tr0_set <= AUTO_RUN & run_q[0];
            tr1_set <= AUTO_RUN & run_q[1];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oc8051_tc_seq.sv
// ---------------------------------------------------------------------------
// tb_oc8051_tc_seq
//
// Self-checking bench for oc8051_tc_seq. For each sequence, the stimulus
// task builds the expected port activity for every busy cycle. This comes
// from a cycle-walk over the five registers that follows the loading rules:
// CPU writes win, enabled steps wait for a free port, and disabled steps
// are skipped. The expected records go into a scoreboard queue. A monitor
// samples the DUT on the falling edge and pops one record each time the DUT
// shows activity (busy, a write, done, or run requests).
// A second instance with AUTO_RUN=0 must never request run bits.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_oc8051_tc_seq;

  typedef struct {
    int          cyc;
    logic [21:0] v;   // {busy, done, tr0, tr1, wr, wr_bit, addr[7:0], data[7:0]}
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_wr = 1'b0;
  logic       cpu_wr_bit = 1'b0;
  logic [7:0] cpu_wr_addr = 8'h00;
  logic [7:0] cpu_data_in = 8'h00;
  logic       cfg_start = 1'b0;
  logic [4:0] cfg_mask = 5'h00;
  logic [7:0] cfg_tmod = 8'h00;
  logic [7:0] cfg_th0 = 8'h00;
  logic [7:0] cfg_tl0 = 8'h00;
  logic [7:0] cfg_th1 = 8'h00;
  logic [7:0] cfg_tl1 = 8'h00;
  logic [1:0] cfg_run = 2'b00;

  logic       wr, wr_bit, busy, done, tr0_set, tr1_set;
  logic [7:0] wr_addr, data_in;
  logic       b_wr, b_wr_bit, b_busy, b_done, b_tr0_set, b_tr1_set;
  logic [7:0] b_wr_addr, b_data_in;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  rec_t sb[$];

  // CPU traffic plan for the next sequence, indexed by sequence cycle
  bit         cpu_on [32];
  logic       cpu_b  [32];
  logic [7:0] cpu_a  [32];
  logic [7:0] cpu_d  [32];

  oc8051_tc_seq #(.AUTO_RUN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cpu_wr(cpu_wr), .cpu_wr_bit(cpu_wr_bit), .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in),
    .cfg_start(cfg_start), .cfg_mask(cfg_mask),
    .cfg_tmod(cfg_tmod), .cfg_th0(cfg_th0), .cfg_tl0(cfg_tl0), .cfg_th1(cfg_th1), .cfg_tl1(cfg_tl1),
    .cfg_run(cfg_run),
    .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr), .data_in(data_in),
    .busy(busy), .done(done), .tr0_set(tr0_set), .tr1_set(tr1_set)
  );

  oc8051_tc_seq #(.AUTO_RUN(1'b0)) dut_norun (
    .clk(clk), .rst(rst),
    .cpu_wr(cpu_wr), .cpu_wr_bit(cpu_wr_bit), .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in),
    .cfg_start(cfg_start), .cfg_mask(cfg_mask),
    .cfg_tmod(cfg_tmod), .cfg_th0(cfg_th0), .cfg_tl0(cfg_tl0), .cfg_th1(cfg_th1), .cfg_tl1(cfg_tl1),
    .cfg_run(cfg_run),
    .wr(b_wr), .wr_bit(b_wr_bit), .wr_addr(b_wr_addr), .data_in(b_data_in),
    .busy(b_busy), .done(b_done), .tr0_set(b_tr0_set), .tr1_set(b_tr1_set)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // Monitor: every active cycle must match the next scoreboard record
  always @(negedge clk) begin
    logic [21:0] act;
    rec_t        e;
    if (rst && (busy || wr || done || tr0_set || tr1_set)) begin
      act = {busy, done, tr0_set, tr1_set, wr, wr_bit, wr_addr, data_in};
      if (sb.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_activity at cyc %0d: actual=%h required=none", cyc, act);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc == cyc && e.v === act) n_pass++;
        else $display("[TB] FAIL port_cycle: actual cyc=%0d val=%h required cyc=%0d val=%h",
                      cyc, act, e.cyc, e.v);
        if (e.v[20]) checkOutput("norun_tr_bits", {30'd0, b_tr0_set, b_tr1_set}, 32'd0);
      end
    end
  end

  task automatic clearCpu();
    for (int i = 0; i < 32; i++) begin
      cpu_on[i] = 1'b0;
      cpu_b[i]  = 1'b0;
      cpu_a[i]  = 8'h00;
      cpu_d[i]  = 8'h00;
    end
  endtask

  task automatic randomJunk();
    cfg_mask = 5'($urandom);
    cfg_tmod = 8'($urandom);
    cfg_th0  = 8'($urandom);
    cfg_tl0  = 8'($urandom);
    cfg_th1  = 8'($urandom);
    cfg_tl1  = 8'($urandom);
    cfg_run  = 2'($urandom);
  endtask

  // Runs one sequence. keep holds cfg_start high through done. A nonzero
  // abort_at asserts reset at that sequence cycle.
  task automatic applyStimulus(input logic [4:0] mask, input logic [7:0] v0, input logic [7:0] v1,
                               input logic [7:0] v2, input logic [7:0] v3, input logic [7:0] v4,
                               input logic [1:0] run, input bit keep, input int abort_at);
    logic [7:0] vals [5];
    logic [7:0] addrs [5];
    rec_t       r;
    int         k, j, last, base;
    vals  = '{v0, v1, v2, v3, v4};
    addrs = '{8'h89, 8'h8C, 8'h8A, 8'h8D, 8'h8B};

    @(posedge clk); #2;
    base        = cyc;
    cfg_start   = 1'b1;
    cfg_mask    = mask;
    cfg_tmod    = v0;
    cfg_th0     = v1;
    cfg_tl0     = v2;
    cfg_th1     = v3;
    cfg_tl1     = v4;
    cfg_run     = run;
    cpu_wr      = 1'b0;
    cpu_wr_bit  = 1'($urandom);
    cpu_wr_addr = 8'($urandom);
    cpu_data_in = 8'($urandom);

    // Reference: walk cycles, k = register being loaded
    k = 0;
    j = 1;
    last = 0;
    forever begin
      r.cyc = base + j;
      r.v   = 22'd0;
      r.v[21] = 1'b1;
      if (cpu_on[j]) begin
        r.v[17] = 1'b1;
        r.v[16] = cpu_b[j];
        r.v[15:8] = cpu_a[j];
        r.v[7:0] = cpu_d[j];
      end else if (k < 5 && mask[k]) begin
        r.v[17] = 1'b1;
        r.v[15:8] = addrs[k];
        r.v[7:0] = vals[k];
      end
      if (k == 5) begin
        r.v[20] = 1'b1;
        r.v[19] = run[0];
        r.v[18] = run[1];
        last = j;
      end
      if (abort_at == 0 || j < abort_at) sb.push_back(r);
      if (k == 5) break;
      if (!mask[k] || !cpu_on[j]) k++;
      j++;
    end

    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #2;
      if (c == abort_at) begin
        cpu_wr    = 1'b0;
        cfg_start = 1'b0;
        rst       = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_wr", {31'd0, wr}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        return;
      end
      cfg_start = keep ? 1'b1 : ((c < last) ? 1'($urandom) : 1'b0);
      randomJunk();
      cpu_wr = cpu_on[c];
      if (cpu_on[c]) begin
        cpu_wr_bit  = cpu_b[c];
        cpu_wr_addr = cpu_a[c];
        cpu_data_in = cpu_d[c];
      end else begin
        cpu_wr_bit  = 1'($urandom);
        cpu_wr_addr = 8'($urandom);
        cpu_data_in = 8'($urandom);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit prev_keep;
    bit keep;
    clearCpu();

    // Reset state: outputs idle, port follows CPU
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_tr", {30'd0, tr0_set, tr1_set}, 32'd0);
    checkOutput("reset_idle_port", {wr, wr_bit, wr_addr, data_in}, 32'd0);
    cpu_wr = 1'b1; cpu_wr_bit = 1'b1; cpu_wr_addr = 8'h55; cpu_data_in = 8'hAA;
    #1;
    checkOutput("reset_cpu_pass", {14'd0, wr, wr_bit, wr_addr, data_in}, {14'd0, 2'b11, 8'h55, 8'hAA});
    cpu_wr = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk);

    $display("[TB] full load, no CPU traffic");
    applyStimulus(5'h1F, 8'h21, 8'hF0, 8'h10, 8'hFD, 8'hFD, 2'b00, 1'b0, 0);

    $display("[TB] CPU writes in cycles 2 and 3");
    cpu_on[2] = 1'b1; cpu_a[2] = 8'hA8; cpu_d[2] = 8'h82;
    cpu_on[3] = 1'b1; cpu_a[3] = 8'hA8; cpu_d[3] = 8'h82;
    applyStimulus(5'h1F, 8'h21, 8'hF0, 8'h10, 8'hFD, 8'hFD, 2'b00, 1'b0, 0);
    clearCpu();

    $display("[TB] partial mask with tr1 request");
    applyStimulus(5'b00101, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 2'b10, 1'b0, 0);

    $display("[TB] empty mask");
    applyStimulus(5'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 2'b01, 1'b0, 0);

    $display("[TB] start held high, back-to-back");
    applyStimulus(5'h1F, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 2'b11, 1'b1, 0);
    applyStimulus(5'h1F, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 2'b00, 1'b0, 0);

    $display("[TB] reset in cycle 3, then full sequence");
    applyStimulus(5'h1F, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 2'b11, 1'b0, 3);
    @(posedge clk); #2;
    checkOutput("post_abort_busy", {31'd0, busy}, 32'd0);
    applyStimulus(5'h1F, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 2'b01, 1'b0, 0);

    $display("[TB] randomized sequences");
    prev_keep = 1'b0;
    for (int n = 0; n < 40; n++) begin
      clearCpu();
      for (int c = 1; c <= 12; c++) begin
        cpu_on[c] = ($urandom_range(3) == 0);
        cpu_b[c]  = 1'($urandom);
        cpu_a[c]  = 8'($urandom);
        cpu_d[c]  = 8'($urandom);
      end
      if (!prev_keep) begin
        repeat ($urandom_range(2)) begin
          @(posedge clk); #2;
          cfg_start = 1'b0;
          cpu_wr    = 1'b0;
        end
      end
      keep = (n < 39) && ($urandom_range(3) == 0);
      applyStimulus(5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 2'($urandom), keep, 0);
      prev_keep = keep;
    end
    clearCpu();

    @(posedge clk); #2;
    cfg_start = 1'b0;
    cpu_wr    = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
